am2940_counter_unit: RTL and testbench
======================================

Name: am2940_counter_unit

Overview:
- Address/word-count datapath of the Am2940 DMA generator, directly downstream of the 4-bit control register.
- Consumes the control word (CR[2:0]) and the instruction field.
- Holds the address and word-count registers and counters, steps them on ENABLE, and produces the DONE flag according to the control mode.
- Feeds the output mux (address/word-count readback) and the external DONE pin.

Parameters:
- WIDTH, 4, width of data bus, address and word-count registers/counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- instr  input  3  instruction field; codes 4-7 act here, codes 0-3 are no-ops for this block.
- di  input  WIDTH  load data for address/word-count registers.
- cr  input  3  control word from the control register; cr[1:0]=mode, cr[2]=address direction (0 up, 1 down).
- acen  input  1  address counter enable, active high, effective only under ENABLE.
- wcen  input  1  word counter enable, active high, effective only under ENABLE.
- addr  output  WIDTH  current address counter value.
- wc  output  WIDTH  current word counter value.
- done  output  1  transfer-complete flag, combinational from current state and cr.

Behaviour:
- State: addr_reg, addr_cnt, wc_reg, wc_cnt (each WIDTH bits). addr=addr_cnt, wc=wc_cnt.
- Reset (rst_n=0 at rising clk): all four registers cleared to 0; overrides any instr. After reset, done is 1 in mode 00, mode 01 and mode 10 (all values 0), and 0 in mode 11.
- Instruction codes (localparams):
  - 4 REINIT: addr_cnt<=addr_reg; wc_cnt<=wc_reg, except mode 01 where wc_cnt<=0.
  - 5 LOAD_ADDR: addr_reg<=di; addr_cnt<=di.
  - 6 LOAD_WC: wc_reg<=di; wc_cnt<=di, except mode 01 where wc_cnt<=0.
  - 7 ENABLE: count as below.
  - 0-3: hold all state.
- ENABLE with done=0:
  - If acen=1, addr_cnt steps +1 (cr[2]=0) or -1 (cr[2]=1), modulo 2^WIDTH (0xF+1 -> 0x0, 0x0-1 -> 0xF).
  - If wcen=1, wc_cnt steps per mode: 00 decrement, 01 increment, 10 hold, 11 increment, modulo 2^WIDTH.
  - acen and wcen are independent; both may step in the same cycle.
- ENABLE with done=1: all counters hold. No overrun past the terminal count.
- done decode:
  - 00 WC_ZERO: wc_cnt==0.
  - 01 WC_CMP: wc_cnt==wc_reg.
  - 10 ADDR_CMP: addr_cnt==wc_reg.
  - 11 WC_CARRY: wc_cnt==all-ones.
- Latency:
  - Loads and counts are visible on addr/wc one cycle after the instr edge.
  - done follows in the same cycle as the counter update (no extra register).
- cr change is combinational into the done decode; a new mode takes effect on the next ENABLE edge. Counter contents are not rewritten on a mode change.
- Loading wc_reg so that done is immediately true (e.g. wc=0 in mode 00) is legal. ENABLE then holds at once.
- Reset asserted mid-ENABLE: reset wins; counters read 0 the next cycle.

Decomposition:
- Shared package am2940_pkg holds:
  - instruction codes (INSTR_REINIT=4, INSTR_LOAD_ADDR=5, INSTR_LOAD_WC=6, INSTR_ENABLE=7);
  - mode codes (MODE_WC_ZERO, MODE_WC_CMP, MODE_ADDR_CMP, MODE_WC_CARRY);
  - CR bit indices (CR_DIR=2).
- One natural sub-module, am2940_updown_counter: WIDTH-bit loadable counter with enable, direction and hold. Instantiated for address and word counters.
- done decode and instruction decode stay in the top.

Test Plan:
1. Reset and load: rst_n=0 for 1 cycle, then LOAD_ADDR di=0x3, LOAD_WC di=0x2, cr=000, ENABLE acen=wcen=1 for 4 cycles -> addr 3,4,5 then holds 5; wc 2,1,0 then holds 0; done rises when wc=0.
2. Address down and wrap: cr=100, LOAD_ADDR 0x1, LOAD_WC 0x5, ENABLE 3 cycles -> addr 1,0,F,E; wc 5,4,3,2; done=0 throughout.
3. Mode 01 compare: cr=001, LOAD_WC di=0x3 -> wc=0, done=0. ENABLE -> wc 1,2,3; done=1 at wc=3. Further ENABLE holds wc=3. REINIT -> wc=0, done=0.
4. Mode 10 address compare: cr=010, LOAD_WC 0x6, LOAD_ADDR 0x4, ENABLE acen=1 wcen=1 -> wc holds 6; addr 5,6; done=1 at addr=6; addr frozen after.
5. Mode 11 carry and enable gating: cr=011, LOAD_WC 0xD, ENABLE with wcen=0 for 2 cycles -> wc stays D. Then wcen=1 -> E,F; done=1 at F; hold.
6. Reset mid-operation plus no-op codes: during ENABLE counting (addr=7), drive instr=2 for one cycle -> no change. Then rst_n=0 together with instr=7 -> addr=wc=0 next cycle, done=1 in mode 00.

Source files
------------

// File: rtl/am2940_pkg.sv
// Shared encodings for the Am2940 DMA address/word-count datapath.
package am2940_pkg;

    localparam logic [2:0] INSTR_REINIT    = 3'd4;
    localparam logic [2:0] INSTR_LOAD_ADDR = 3'd5;
    localparam logic [2:0] INSTR_LOAD_WC   = 3'd6;
    localparam logic [2:0] INSTR_ENABLE    = 3'd7;

    localparam logic [1:0] MODE_WC_ZERO  = 2'b00;
    localparam logic [1:0] MODE_WC_CMP   = 2'b01;
    localparam logic [1:0] MODE_ADDR_CMP = 2'b10;
    localparam logic [1:0] MODE_WC_CARRY = 2'b11;

    localparam int unsigned CR_DIR = 2;

endpackage

// File: rtl/am2940_updown_counter.sv
// Loadable modulo-2^WIDTH up/down counter; load has priority over count, otherwise holds.
module am2940_updown_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    input  logic             down_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = down_i ? cnt_q - 1'b1 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/am2940_counter_unit.sv
// Am2940 address/word-count registers and counters with mode-dependent DONE decode.
module am2940_counter_unit
    import am2940_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       instr,
    input  logic [WIDTH-1:0] di,
    input  logic [2:0]       cr,
    input  logic             acen,
    input  logic             wcen,
    output logic [WIDTH-1:0] addr,
    output logic [WIDTH-1:0] wc,
    output logic             done
);

    logic [1:0]       mode;
    logic [WIDTH-1:0] addr_reg_q, addr_reg_d;
    logic [WIDTH-1:0] wc_reg_q, wc_reg_d;
    logic [WIDTH-1:0] addr_cnt, wc_cnt;

    logic             addr_load, addr_en;
    logic [WIDTH-1:0] addr_load_val;
    logic             wc_load, wc_en, wc_down;
    logic [WIDTH-1:0] wc_load_val;
    logic             count_ok;

    assign mode = cr[1:0];

    always_comb begin
        unique case (mode)
            MODE_WC_ZERO:  done = (wc_cnt == '0);
            MODE_WC_CMP:   done = (wc_cnt == wc_reg_q);
            MODE_ADDR_CMP: done = (addr_cnt == wc_reg_q);
            MODE_WC_CARRY: done = (wc_cnt == '1);
            default:       done = 1'b0;
        endcase
    end

    // Counting stops at the terminal condition so the counters never overrun.
    assign count_ok = (instr == INSTR_ENABLE) && !done;

    always_comb begin
        addr_reg_d    = addr_reg_q;
        wc_reg_d      = wc_reg_q;
        addr_load     = 1'b0;
        addr_load_val = addr_reg_q;
        wc_load       = 1'b0;
        wc_load_val   = wc_reg_q;
        unique case (instr)
            INSTR_REINIT: begin
                addr_load   = 1'b1;
                wc_load     = 1'b1;
                wc_load_val = (mode == MODE_WC_CMP) ? '0 : wc_reg_q;
            end
            INSTR_LOAD_ADDR: begin
                addr_reg_d    = di;
                addr_load     = 1'b1;
                addr_load_val = di;
            end
            INSTR_LOAD_WC: begin
                wc_reg_d    = di;
                wc_load     = 1'b1;
                wc_load_val = (mode == MODE_WC_CMP) ? '0 : di;
            end
            default: ;
        endcase
    end

    assign addr_en = count_ok && acen;
    assign wc_en   = count_ok && wcen && (mode != MODE_ADDR_CMP);
    assign wc_down = (mode == MODE_WC_ZERO);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_reg_q <= '0;
            wc_reg_q   <= '0;
        end else begin
            addr_reg_q <= addr_reg_d;
            wc_reg_q   <= wc_reg_d;
        end
    end

    am2940_updown_counter #(
        .WIDTH (WIDTH)
    ) u_addr_cnt (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .load_i     (addr_load),
        .load_val_i (addr_load_val),
        .en_i       (addr_en),
        .down_i     (cr[CR_DIR]),
        .q_o        (addr_cnt)
    );

    am2940_updown_counter #(
        .WIDTH (WIDTH)
    ) u_wc_cnt (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .load_i     (wc_load),
        .load_val_i (wc_load_val),
        .en_i       (wc_en),
        .down_i     (wc_down),
        .q_o        (wc_cnt)
    );

    assign addr = addr_cnt;
    assign wc   = wc_cnt;

endmodule

// File: tb/tb_am2940_counter_unit.sv
// Directed bench for am2940_counter_unit with hand-computed expectations.
module tb_am2940_counter_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] instr;
    logic [3:0] di;
    logic [2:0] cr;
    logic       acen;
    logic       wcen;
    logic [3:0] addr;
    logic [3:0] wc;
    logic       done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    am2940_counter_unit #(
        .WIDTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .instr (instr),
        .di    (di),
        .cr    (cr),
        .acen  (acen),
        .wcen  (wcen),
        .addr  (addr),
        .wc    (wc),
        .done  (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [3:0] ea, input logic [3:0] ew,
                        input logic ed);
        chk({tag, ".addr"}, addr, ea);
        chk({tag, ".wc"}, wc, ew);
        chk({tag, ".done"}, {3'b0, done}, {3'b0, ed});
    endtask

    initial begin
        rst_n = 1'b0; instr = 3'd0; di = 4'h0; cr = 3'b000; acen = 1'b0; wcen = 1'b0;
        #2;

        // 1: reset, load, count down to zero and hold
        step(); chk3("rst", 4'h0, 4'h0, 1'b1);
        rst_n = 1'b1;
        instr = 3'd5; di = 4'h3; step(); chk3("t1.la", 4'h3, 4'h0, 1'b1);
        instr = 3'd6; di = 4'h2; step(); chk3("t1.lw", 4'h3, 4'h2, 1'b0);
        instr = 3'd7; acen = 1'b1; wcen = 1'b1;
        step(); chk3("t1.e1", 4'h4, 4'h1, 1'b0);
        step(); chk3("t1.e2", 4'h5, 4'h0, 1'b1);
        step(); chk3("t1.e3", 4'h5, 4'h0, 1'b1);
        step(); chk3("t1.e4", 4'h5, 4'h0, 1'b1);

        // 2: address down with wrap
        cr = 3'b100;
        instr = 3'd5; di = 4'h1; step(); chk3("t2.la", 4'h1, 4'h0, 1'b1);
        instr = 3'd6; di = 4'h5; step(); chk3("t2.lw", 4'h1, 4'h5, 1'b0);
        instr = 3'd7;
        step(); chk3("t2.e1", 4'h0, 4'h4, 1'b0);
        step(); chk3("t2.e2", 4'hF, 4'h3, 1'b0);
        step(); chk3("t2.e3", 4'hE, 4'h2, 1'b0);

        // 3: mode 01 compare against loaded word count
        cr = 3'b001; acen = 1'b0;
        instr = 3'd6; di = 4'h3; step(); chk3("t3.lw", 4'hE, 4'h0, 1'b0);
        instr = 3'd7;
        step(); chk3("t3.e1", 4'hE, 4'h1, 1'b0);
        step(); chk3("t3.e2", 4'hE, 4'h2, 1'b0);
        step(); chk3("t3.e3", 4'hE, 4'h3, 1'b1);
        step(); chk3("t3.e4", 4'hE, 4'h3, 1'b1);
        instr = 3'd4; step(); chk3("t3.ri", 4'h1, 4'h0, 1'b0);

        // 4: mode 10 address compare, word counter frozen
        cr = 3'b010;
        instr = 3'd6; di = 4'h6; step(); chk3("t4.lw", 4'h1, 4'h6, 1'b0);
        instr = 3'd5; di = 4'h4; step(); chk3("t4.la", 4'h4, 4'h6, 1'b0);
        instr = 3'd7; acen = 1'b1; wcen = 1'b1;
        step(); chk3("t4.e1", 4'h5, 4'h6, 1'b0);
        step(); chk3("t4.e2", 4'h6, 4'h6, 1'b1);
        step(); chk3("t4.e3", 4'h6, 4'h6, 1'b1);

        // 5: mode 11 carry with enable gating
        cr = 3'b011; acen = 1'b0; wcen = 1'b0;
        instr = 3'd6; di = 4'hD; step(); chk3("t5.lw", 4'h6, 4'hD, 1'b0);
        instr = 3'd7;
        step(); chk3("t5.g1", 4'h6, 4'hD, 1'b0);
        step(); chk3("t5.g2", 4'h6, 4'hD, 1'b0);
        wcen = 1'b1;
        step(); chk3("t5.e1", 4'h6, 4'hE, 1'b0);
        step(); chk3("t5.e2", 4'h6, 4'hF, 1'b1);
        step(); chk3("t5.e3", 4'h6, 4'hF, 1'b1);

        // 6: no-op code then reset during ENABLE
        cr = 3'b000; acen = 1'b1;
        instr = 3'd5; di = 4'h5; step(); chk3("t6.la", 4'h5, 4'hF, 1'b0);
        instr = 3'd6; di = 4'h9; step(); chk3("t6.lw", 4'h5, 4'h9, 1'b0);
        instr = 3'd7;
        step(); chk3("t6.e1", 4'h6, 4'h8, 1'b0);
        step(); chk3("t6.e2", 4'h7, 4'h7, 1'b0);
        instr = 3'd2; step(); chk3("t6.nop", 4'h7, 4'h7, 1'b0);
        instr = 3'd7; rst_n = 1'b0; step(); chk3("t6.rst", 4'h0, 4'h0, 1'b1);
        cr = 3'b011; #1;
        chk("t6.m11done", {3'b0, done}, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
